// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: PID encodings, packet classes and parser states.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {CLS_TOKEN, CLS_DATA, CLS_HS, CLS_OTHER} pkt_class_t;

  typedef enum logic [2:0] {ST_IDLE, ST_TOKEN, ST_DATA, ST_HS, ST_DRAIN} rx_state_t;

  function automatic pkt_class_t pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SETUP, PID_SOF: pid_class = CLS_TOKEN;
      PID_DATA0, PID_DATA1:                pid_class = CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL:         pid_class = CLS_HS;
      default:                             pid_class = CLS_OTHER;
    endcase
  endfunction

  function automatic rx_state_t class_state(input pkt_class_t cls);
    case (cls)
      CLS_TOKEN: class_state = ST_TOKEN;
      CLS_DATA:  class_state = ST_DATA;
      CLS_HS:    class_state = ST_HS;
      default:   class_state = ST_DRAIN;
    endcase
  endfunction

endpackage

// File: rtl/rx_byte_delay2.sv
// Two-entry byte delay line; a push into a full line shifts out the oldest byte,
// which keeps the final two bytes (the CRC16) of a data packet from ever leaving.
module rx_byte_delay2 (
  input  logic       clk48,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] din_i,
  output logic [1:0] count_o,
  output logic       emit_o,
  output logic [7:0] emit_byte_o
);

  logic [7:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge clk48) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    e0_d        = e0_q;
    e1_d        = e1_q;
    cnt_d       = cnt_q;
    emit_o      = 1'b0;
    emit_byte_o = e0_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (push_i) begin
      case (cnt_q)
        2'd0: begin e0_d = din_i; cnt_d = 2'd1; end
        2'd1: begin e1_d = din_i; cnt_d = 2'd2; end
        default: begin
          emit_o = 1'b1;
          e0_d   = e1_q;
          e1_d   = din_i;
        end
      endcase
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/rx_packet_parser.sv
// Classifies decoded USB packets and extracts token/SOF fields, handshake PIDs and
// CRC-stripped data payload with an end-of-data verdict.
module rx_packet_parser
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 64,
  localparam int LEN_W   = $clog2(MAX_DATA + 1)
) (
  input  logic             clk48,
  input  logic             reset,
  input  logic             bus_reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_in_valid,
  input  logic [3:0]       packet_kind,
  input  logic             packet_kind_valid,
  input  logic             packet_valid,
  input  logic             packet_eop,
  output logic             token_valid,
  output logic [3:0]       token_pid,
  output logic [6:0]       token_addr,
  output logic [3:0]       token_endp,
  output logic             sof_valid,
  output logic [10:0]      frame_num,
  output logic [3:0]       data_pid,
  output logic [7:0]       data_byte,
  output logic             data_byte_valid,
  output logic             data_done,
  output logic             data_ok,
  output logic [LEN_W-1:0] data_len,
  output logic             hs_valid,
  output logic [3:0]       hs_pid,
  output logic             rx_error
);

  rx_state_t        state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       byte0_q, byte0_d, byte1_q, byte1_d;
  logic             overflow_q, overflow_d;
  logic             token_valid_q, token_valid_d, sof_valid_q, sof_valid_d;
  logic             hs_valid_q, hs_valid_d, rx_error_q, rx_error_d;
  logic             data_done_q, data_done_d, data_ok_q, data_ok_d;
  logic             data_byte_valid_q, data_byte_valid_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic [3:0]       token_pid_q, token_pid_d, data_pid_q, data_pid_d, hs_pid_q, hs_pid_d;
  logic [6:0]       token_addr_q, token_addr_d;
  logic [3:0]       token_endp_q, token_endp_d;
  logic [10:0]      frame_num_q, frame_num_d;
  logic [LEN_W-1:0] data_len_q, data_len_d;

  logic             dl_flush, dl_push, dl_emit;
  logic [1:0]       dl_count;
  logic [7:0]       dl_byte;
  logic             in_packet;
  logic [3:0]       cur_pid;
  pkt_class_t       cur_cls;
  logic [7:0]       eval_cnt;
  logic             eval_ovf;

  rx_byte_delay2 u_delay (
    .clk48       (clk48),
    .reset       (reset),
    .flush_i     (dl_flush),
    .push_i      (dl_push),
    .din_i       (byte_in),
    .count_o     (dl_count),
    .emit_o      (dl_emit),
    .emit_byte_o (dl_byte)
  );

  always_ff @(posedge clk48) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus_reset)
      state_d = ST_IDLE;
    else if (state_q == ST_IDLE) begin
      if (packet_kind_valid && !packet_eop)
        state_d = class_state(pid_class(packet_kind));
    end else if (packet_eop)
      state_d = ST_IDLE;
  end

  // A PID and eop in the same IDLE cycle is a zero-byte packet evaluated on the spot.
  assign in_packet = (state_q != ST_IDLE);
  assign cur_pid   = in_packet ? pid_q : packet_kind;
  assign cur_cls   = pid_class(cur_pid);
  assign eval_cnt  = in_packet ? cnt_q : 8'd0;
  assign eval_ovf  = in_packet && overflow_q;

  always_comb begin
    pid_d = pid_q;  cnt_d = cnt_q;  byte0_d = byte0_q;  byte1_d = byte1_q;
    overflow_d = overflow_q;
    token_valid_d = 1'b0;  sof_valid_d = 1'b0;  hs_valid_d = 1'b0;
    rx_error_d = 1'b0;  data_done_d = 1'b0;  data_byte_valid_d = 1'b0;
    data_ok_d = data_ok_q;  data_byte_d = data_byte_q;
    token_pid_d = token_pid_q;  token_addr_d = token_addr_q;  token_endp_d = token_endp_q;
    frame_num_d = frame_num_q;  data_pid_d = data_pid_q;  hs_pid_d = hs_pid_q;
    data_len_d = data_len_q;
    dl_flush = bus_reset || !in_packet;
    dl_push  = 1'b0;
    if (bus_reset) begin
      cnt_d      = 8'd0;
      overflow_d = 1'b0;
    end else begin
      if (!in_packet && packet_kind_valid) begin
        pid_d      = packet_kind;
        cnt_d      = 8'd0;
        overflow_d = 1'b0;
        if (cur_cls == CLS_DATA) begin
          data_pid_d = packet_kind;
          data_len_d = '0;
        end
      end
      if (in_packet && byte_in_valid && !packet_eop) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (state_q == ST_TOKEN && cnt_q == 8'd0) byte0_d = byte_in;
        if (state_q == ST_TOKEN && cnt_q == 8'd1) byte1_d = byte_in;
        if (state_q == ST_DATA) begin
          dl_push = 1'b1;
          if (dl_emit && dl_count == 2'd2) begin
            if (data_len_q == LEN_W'(MAX_DATA)) begin
              overflow_d = 1'b1;
            end else begin
              data_byte_valid_d = 1'b1;
              data_byte_d       = dl_byte;
              data_len_d        = data_len_q + 1'b1;
            end
          end
        end
      end
      if (packet_eop && (in_packet || packet_kind_valid)) begin
        case (cur_cls)
          CLS_TOKEN: begin
            if (packet_valid && eval_cnt == 8'd2) begin
              if (cur_pid == PID_SOF) begin
                sof_valid_d = 1'b1;
                frame_num_d = {byte1_q[2:0], byte0_q};
              end else begin
                token_valid_d = 1'b1;
                token_pid_d   = cur_pid;
                token_addr_d  = byte0_q[6:0];
                token_endp_d  = {byte1_q[2:0], byte0_q[7]};
              end
            end else begin
              rx_error_d = 1'b1;
            end
          end
          CLS_DATA: begin
            data_done_d = 1'b1;
            data_ok_d   = packet_valid && (eval_cnt >= 8'd2) && !eval_ovf;
          end
          CLS_HS: begin
            if (eval_cnt == 8'd0) begin
              hs_valid_d = 1'b1;
              hs_pid_d   = cur_pid;
            end else begin
              rx_error_d = 1'b1;
            end
          end
          default: rx_error_d = 1'b1;
        endcase
      end else if (packet_eop) begin
        rx_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      pid_q <= '0;  cnt_q <= '0;  byte0_q <= '0;  byte1_q <= '0;  overflow_q <= 1'b0;
      token_valid_q <= 1'b0;  sof_valid_q <= 1'b0;  hs_valid_q <= 1'b0;  rx_error_q <= 1'b0;
      data_done_q <= 1'b0;  data_ok_q <= 1'b0;  data_byte_valid_q <= 1'b0;  data_byte_q <= '0;
      token_pid_q <= '0;  token_addr_q <= '0;  token_endp_q <= '0;  frame_num_q <= '0;
      data_pid_q <= '0;  hs_pid_q <= '0;  data_len_q <= '0;
    end else begin
      pid_q <= pid_d;  cnt_q <= cnt_d;  byte0_q <= byte0_d;  byte1_q <= byte1_d;
      overflow_q <= overflow_d;
      token_valid_q <= token_valid_d;  sof_valid_q <= sof_valid_d;
      hs_valid_q <= hs_valid_d;  rx_error_q <= rx_error_d;
      data_done_q <= data_done_d;  data_ok_q <= data_ok_d;
      data_byte_valid_q <= data_byte_valid_d;  data_byte_q <= data_byte_d;
      token_pid_q <= token_pid_d;  token_addr_q <= token_addr_d;  token_endp_q <= token_endp_d;
      frame_num_q <= frame_num_d;  data_pid_q <= data_pid_d;  hs_pid_q <= hs_pid_d;
      data_len_q <= data_len_d;
    end
  end

  assign token_valid     = token_valid_q;
  assign token_pid       = token_pid_q;
  assign token_addr      = token_addr_q;
  assign token_endp      = token_endp_q;
  assign sof_valid       = sof_valid_q;
  assign frame_num       = frame_num_q;
  assign data_pid        = data_pid_q;
  assign data_byte       = data_byte_q;
  assign data_byte_valid = data_byte_valid_q;
  assign data_done       = data_done_q;
  assign data_ok         = data_ok_q;
  assign data_len        = data_len_q;
  assign hs_valid        = hs_valid_q;
  assign hs_pid          = hs_pid_q;
  assign rx_error        = rx_error_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed bench for rx_packet_parser: token, SOF, data, overflow, handshake, error and bus reset cases.
module tb_rx_packet_parser;

  logic        clk48 = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic [3:0]  packet_kind = '0;
  logic        packet_kind_valid = 1'b0;
  logic        packet_valid = 1'b0;
  logic        packet_eop = 1'b0;
  logic        token_valid, sof_valid, data_byte_valid, data_done, data_ok, hs_valid, rx_error;
  logic [3:0]  token_pid, token_endp, data_pid, hs_pid;
  logic [6:0]  token_addr;
  logic [10:0] frame_num;
  logic [7:0]  data_byte;
  logic [6:0]  data_len;

  int passed = 0;
  int total  = 0;
  int tok_n = 0, sof_n = 0, hs_n = 0, done_n = 0, err_n = 0;
  logic [7:0] rx_q[$];
  logic       done_ok_seen;
  logic [6:0] done_len_seen;

  rx_packet_parser #(.MAX_DATA(64)) dut (
    .clk48(clk48), .reset(reset), .bus_reset(bus_reset),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid),
    .packet_kind(packet_kind), .packet_kind_valid(packet_kind_valid),
    .packet_valid(packet_valid), .packet_eop(packet_eop),
    .token_valid(token_valid), .token_pid(token_pid), .token_addr(token_addr),
    .token_endp(token_endp), .sof_valid(sof_valid), .frame_num(frame_num),
    .data_pid(data_pid), .data_byte(data_byte), .data_byte_valid(data_byte_valid),
    .data_done(data_done), .data_ok(data_ok), .data_len(data_len),
    .hs_valid(hs_valid), .hs_pid(hs_pid), .rx_error(rx_error)
  );

  always #10 clk48 = ~clk48;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk48) begin
    if (token_valid) tok_n++;
    if (sof_valid)   sof_n++;
    if (hs_valid)    hs_n++;
    if (rx_error)    err_n++;
    if (data_done) begin
      done_n++;
      done_ok_seen  = data_ok;
      done_len_seen = data_len;
    end
    if (data_byte_valid) rx_q.push_back(data_byte);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk48);
      #1;
    end
  endtask

  task automatic start_pkt(input logic [3:0] kind);
    packet_kind = kind;
    packet_kind_valid = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_in_valid = 1'b1;
    tick();
    byte_in_valid = 1'b0;
    tick(2);
  endtask

  task automatic end_pkt(input logic pv);
    packet_eop = 1'b1;
    packet_valid = pv;
    tick();
    packet_eop = 1'b0;
    packet_valid = 1'b0;
    packet_kind_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick(3);
    total++;
    if ({token_valid, sof_valid, hs_valid, data_done, rx_error, data_byte_valid, data_ok} !== 7'b0) begin
      $display("FAIL reset_strobes: got %b required 0000000",
               {token_valid, sof_valid, hs_valid, data_done, rx_error, data_byte_valid, data_ok});
    end else passed++;
    total++;
    if ({token_addr, token_endp, frame_num, data_len, data_pid, hs_pid, token_pid} !== 41'b0) begin
      $display("FAIL reset_fields: got %h required 0",
               {token_addr, token_endp, frame_num, data_len, data_pid, hs_pid, token_pid});
    end else passed++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_out_token;
    int e0;
    e0 = err_n;
    start_pkt(4'b0001);
    send_byte(8'h85);
    send_byte(8'hB0);
    end_pkt(1'b1);
    total++;
    if (token_valid !== 1'b1) $display("FAIL out_token_valid: got %b required 1", token_valid);
    else passed++;
    total++;
    if ({token_addr, token_endp, token_pid} !== {7'h05, 4'h1, 4'b0001})
      $display("FAIL out_token_fields: got addr=%h endp=%h pid=%b required addr=05 endp=1 pid=0001",
               token_addr, token_endp, token_pid);
    else passed++;
    tick();
    total++;
    if (token_valid !== 1'b0) $display("FAIL out_token_one_cycle: got %b required 0", token_valid);
    else passed++;
    tick(3);
    total++;
    if (err_n !== e0) $display("FAIL out_token_no_error: got %0d errors required %0d", err_n, e0);
    else passed++;
  endtask

  task automatic test_sof;
    int t0;
    t0 = tok_n;
    start_pkt(4'b0101);
    send_byte(8'h34);
    send_byte(8'h1A);
    end_pkt(1'b1);
    total++;
    if (sof_valid !== 1'b1 || frame_num !== 11'h234)
      $display("FAIL sof: got valid=%b frame=%h required valid=1 frame=234", sof_valid, frame_num);
    else passed++;
    tick(3);
    total++;
    if (tok_n !== t0) $display("FAIL sof_no_token: got %0d tokens required %0d", tok_n, t0);
    else passed++;
  endtask

  task automatic test_data1;
    logic [7:0] pl[6];
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    rx_q.delete();
    start_pkt(4'b1011);
    total++;
    if (data_pid !== 4'b1011) $display("FAIL data1_pid: got %b required 1011", data_pid);
    else passed++;
    for (int i = 0; i < 6; i++) send_byte(pl[i]);
    end_pkt(1'b1);
    total++;
    if (data_done !== 1'b1 || data_ok !== 1'b1 || data_len !== 7'd4)
      $display("FAIL data1_done: got done=%b ok=%b len=%0d required done=1 ok=1 len=4",
               data_done, data_ok, data_len);
    else passed++;
    tick(3);
    total++;
    if (rx_q.size() != 4 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02 || rx_q[2] !== 8'h03 || rx_q[3] !== 8'h04)
      $display("FAIL data1_payload: got %0d bytes %p required 01 02 03 04", rx_q.size(), rx_q);
    else passed++;
  endtask

  task automatic test_overflow;
    int d0, e0;
    d0 = done_n;
    e0 = err_n;
    rx_q.delete();
    start_pkt(4'b0011);
    for (int i = 0; i < 67; i++) send_byte(8'(i + 16));
    end_pkt(1'b1);
    tick(3);
    total++;
    if (done_n !== d0 + 1 || done_ok_seen !== 1'b0 || done_len_seen !== 7'd64)
      $display("FAIL overflow_done: got dones=%0d ok=%b len=%0d required dones=%0d ok=0 len=64",
               done_n - d0, done_ok_seen, done_len_seen, 1);
    else passed++;
    total++;
    if (rx_q.size() != 64 || rx_q[0] !== 8'h10 || rx_q[63] !== 8'h4F)
      $display("FAIL overflow_payload: got %0d bytes required 64 (10..4F)", rx_q.size());
    else passed++;
    total++;
    if (err_n !== e0) $display("FAIL overflow_no_error: got %0d errors required %0d", err_n, e0);
    else passed++;
  endtask

  task automatic test_handshake;
    int h0;
    start_pkt(4'b0010);
    end_pkt(1'b0);
    total++;
    if (hs_valid !== 1'b1 || hs_pid !== 4'b0010)
      $display("FAIL ack: got valid=%b pid=%b required valid=1 pid=0010", hs_valid, hs_pid);
    else passed++;
    tick(3);
    h0 = hs_n;
    start_pkt(4'b0010);
    send_byte(8'h5A);
    end_pkt(1'b0);
    total++;
    if (rx_error !== 1'b1 || hs_valid !== 1'b0)
      $display("FAIL ack_stray_byte: got err=%b hs=%b required err=1 hs=0", rx_error, hs_valid);
    else passed++;
    tick(3);
    total++;
    if (hs_n !== h0) $display("FAIL ack_stray_no_hs: got %0d required %0d", hs_n, h0);
    else passed++;
  endtask

  task automatic test_errors;
    packet_eop = 1'b1;
    tick();
    packet_eop = 1'b0;
    total++;
    if (rx_error !== 1'b1) $display("FAIL eop_without_pid: got %b required 1", rx_error);
    else passed++;
    tick(3);
    start_pkt(4'b0000);
    send_byte(8'h11);
    end_pkt(1'b1);
    total++;
    if (rx_error !== 1'b1) $display("FAIL unsupported_pid: got %b required 1", rx_error);
    else passed++;
    tick(3);
    start_pkt(4'b1001);
    send_byte(8'h85);
    send_byte(8'hB0);
    end_pkt(1'b0);
    total++;
    if (rx_error !== 1'b1 || token_valid !== 1'b0)
      $display("FAIL token_bad_crc: got err=%b tok=%b required err=1 tok=0", rx_error, token_valid);
    else passed++;
    tick(3);
  endtask

  task automatic test_bus_reset;
    int d0, e0, t0;
    d0 = done_n;
    e0 = err_n;
    t0 = tok_n;
    rx_q.delete();
    start_pkt(4'b0011);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    bus_reset = 1'b1;
    packet_eop = 1'b1;
    packet_valid = 1'b1;
    tick();
    bus_reset = 1'b0;
    packet_eop = 1'b0;
    packet_valid = 1'b0;
    packet_kind_valid = 1'b0;
    tick(4);
    total++;
    if (done_n !== d0 || err_n !== e0)
      $display("FAIL bus_reset_silent: got dones=%0d errs=%0d required 0 0", done_n - d0, err_n - e0);
    else passed++;
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC1)
      $display("FAIL bus_reset_partial: got %0d bytes required 1 (C1)", rx_q.size());
    else passed++;
    start_pkt(4'b1001);
    send_byte(8'h85);
    send_byte(8'hB0);
    end_pkt(1'b1);
    total++;
    if (token_valid !== 1'b1 || token_pid !== 4'b1001 || token_addr !== 7'h05 || token_endp !== 4'h1)
      $display("FAIL in_after_reset: got v=%b pid=%b addr=%h endp=%h required v=1 pid=1001 addr=05 endp=1",
               token_valid, token_pid, token_addr, token_endp);
    else passed++;
    tick(3);
    total++;
    if (tok_n !== t0 + 1 || done_n !== d0)
      $display("FAIL in_after_reset_counts: got tok=%0d done=%0d required 1 0", tok_n - t0, done_n - d0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_out_token();
    test_sof();
    test_data1();
    test_overflow();
    test_handshake();
    test_errors();
    test_bus_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rx_packet_parser.md
# rx_packet_parser

Receive-side packet field extractor, directly downstream of the bit/byte-level packet decoder. It consumes the decoder's byte stream, PID and end-of-packet strobes and classifies each packet as token, SOF, data or handshake. Tokens become address/endpoint fields, SOF becomes a frame number, handshakes become a PID strobe, and data payload becomes a byte stream with the trailing CRC16 removed plus an end-of-data verdict. Output feeds the endpoint/protocol engine.

## Interface
- MAX_DATA, 64: maximum data payload bytes, excluding CRC, before overflow is flagged.
- clk48  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bus_reset  in  1  USB bus reset from decoder; aborts current packet.
- byte_in  in  8  decoder byte, LSB-first assembled.
- byte_in_valid  in  1  one-cycle strobe per byte.
- packet_kind  in  4  PID[3:0].
- packet_kind_valid  in  1  PID check passed; high throughout payload.
- packet_valid  in  1  CRC good; sampled with packet_eop.
- packet_eop  in  1  one-cycle end-of-packet strobe.
- token_valid  out  1  strobe: OUT/IN/SETUP token received.
- token_pid  out  4  token PID.
- token_addr  out  7  device address.
- token_endp  out  4  endpoint.
- sof_valid  out  1  strobe: SOF received.
- frame_num  out  11  SOF frame number.
- data_pid  out  4  DATA0/DATA1, latched at packet start.
- data_byte  out  8  payload byte.
- data_byte_valid  out  1  payload byte strobe.
- data_done  out  1  strobe: data packet ended.
- data_ok  out  1  qualifies data_done: payload good.
- data_len  out  $clog2(MAX_DATA+1)  payload bytes emitted.
- hs_valid  out  1  strobe: ACK/NAK/STALL received.
- hs_pid  out  4  handshake PID.
- rx_error  out  1  strobe: malformed or unsupported packet.

## Operation
- All outputs are registered and reset to 0.
- FSM states: IDLE, TOKEN, DATA, HS, DRAIN.
- IDLE: on the first cycle with packet_kind_valid, latch packet_kind and classify it:
  - OUT/IN/SETUP/SOF go to TOKEN.
  - DATA0/DATA1 go to DATA.
  - ACK/NAK/STALL go to HS.
  - Every other PID goes to DRAIN.
- IDLE: packet_eop without packet_kind_valid (truncated PID or PID check fail) pulses rx_error and stays in IDLE.
- All classes: count received bytes; on packet_eop, evaluate and return to IDLE.
- TOKEN: store byte0 and byte1.
  - Pass condition: packet_valid and count==2.
  - OUT/IN/SETUP: token_addr=byte0[6:0]; token_endp={byte1[2:0],byte0[7]}; pulse token_valid.
  - SOF: frame_num={byte1[2:0],byte0}; pulse sof_valid.
  - Fail: pulse rx_error.
- DATA: bytes pass through a 2-byte delay line; a byte is emitted only once two newer bytes exist, so the CRC16 bytes are never emitted.
  - data_len counts emitted bytes.
  - When data_len==MAX_DATA, further emission is suppressed and an overflow flag is set.
  - On eop: pulse data_done with data_ok = packet_valid && count>=2 && !overflow.
  - Consumer discards the buffered payload when data_ok=0; rx_error is not pulsed for data packets.
- HS: on eop, count==0 pulses hs_valid (packet_valid is ignored, since handshakes carry no CRC). Otherwise pulse rx_error.
- DRAIN: ignore bytes; on eop pulse rx_error.
- bus_reset in any state:
  - Return to IDLE and clear the delay line, counters and overflow.
  - Emit no strobes that cycle. bus_reset has priority over a coincident packet_eop.
- Reset mid-packet: same as bus_reset.
- token_addr/endp, frame_num, hs_pid, data_pid and data_len hold until overwritten by the next packet of their class.

## Timing
- Strobes (token_valid, sof_valid, hs_valid, data_done, rx_error): one cycle, asserted the cycle after packet_eop. At most one of them per packet.
- data_byte_valid: the cycle after the byte_in_valid that pushes the delay line from 2 to 3 entries. Byte-to-byte spacing is about 32 clocks; no backpressure.
- The last data_byte_valid is at least 1 cycle before data_done.
- data_len is stable in the data_done cycle.
- Latched field outputs change in the same cycle as their strobe.
- packet_kind_valid is not required to stay high after classification; the latched PID is used.

## Structure
- Shared package usb_pkg holds:
  - PID localparams (OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110).
  - The packet-class enum {TOKEN, DATA, HS, OTHER} and a pid_class() function.
  - The decoder should reuse the same package.
- Sub-module rx_byte_delay2: 2-entry shift register with occupancy count, push, flush and emit outputs.

## Test plan
- OUT token, bytes 0x85 then {crc5,3'b000} with valid CRC, packet_valid=1 → token_valid pulse with token_addr=0x05, token_endp=1, token_pid=0001.
- SOF, bytes 0x34 and {crc5,3'b010}, packet_valid=1 → sof_valid pulse, frame_num=0x234.
- DATA1 with 4 payload bytes 0x01..0x04 + 2 CRC bytes, packet_valid=1 → data_byte 01,02,03,04 in order, data_done with data_ok=1, data_len=4, data_pid=1011.
- DATA0 with 65 payload bytes, MAX_DATA=64 → 64 bytes emitted, data_done with data_ok=0, data_len=64.
- ACK (0 bytes, packet_valid=0) → hs_valid, hs_pid=0010. Same PID followed by 1 stray byte → rx_error only.
- bus_reset asserted mid DATA0 after 3 bytes, followed by a clean IN token → no data_done for the aborted packet; the token decodes correctly.
